// File: rtl/pipe_pkg.sv
// Shared load-path definitions: access-size encodings, the load result record and a
// misalignment helper used by the extract stage.
package pipe_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    // The record is sized for the widest legal configuration; narrower instances zero-pad.
    localparam int unsigned LD_DATA_MAX = 64;
    localparam int unsigned LD_TAG_MAX  = 16;

    typedef struct packed {
        logic [LD_DATA_MAX-1:0] data;
        logic [LD_TAG_MAX-1:0]  tag;
        logic                   err;
    } ld_res_t;

    // Dword is only legal on a 64-bit datapath, and only at offset 0.
    function automatic logic ld_misaligned(input logic [1:0] size, input logic [2:0] off,
                                           input logic is_64);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off[1:0];
            default: bad = !is_64 || (off != 3'd0);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select, sign/zero extension and alignment check for one load beat.
module load_extract
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic [DATA_W-1:0]         data_i,
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  logic [1:0]                size_i,
    input  logic                      signed_i,
    input  logic [TAG_W-1:0]          tag_i,
    output ld_res_t                   res_o
);

    logic [DATA_W-1:0] field;
    logic [DATA_W-1:0] ext;
    logic              err;

    assign field = data_i >> {off_i, 3'b000};

    // Size casts of a $signed operand replicate its MSB, which gives the sign extension.
    always_comb begin
        ext = '0;
        unique case (size_i)
            SZ_BYTE: ext = signed_i ? DATA_W'($signed(field[7:0]))  : DATA_W'(field[7:0]);
            SZ_HALF: ext = signed_i ? DATA_W'($signed(field[15:0])) : DATA_W'(field[15:0]);
            SZ_WORD: ext = signed_i ? DATA_W'($signed(field[31:0])) : DATA_W'(field[31:0]);
            default: ext = field;
        endcase
    end

    assign err = ld_misaligned(size_i, 3'(off_i), DATA_W == 64);

    assign res_o = '{
        data: err ? '0 : LD_DATA_MAX'(ext),
        tag:  LD_TAG_MAX'(tag_i),
        err:  err
    };

endmodule

// File: rtl/load_align_extend.sv
// MEM->WB load-data stage: aligned/extended load result registered behind a
// valid/ready handshake with a one-entry skid register so back-pressure never drops data.
module load_align_extend
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [$clog2(DATA_W/8)-1:0] in_off,
    input  logic [1:0]                  in_size,
    input  logic                        in_signed,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        out_err
);

    ld_res_t ext_res;
    ld_res_t main_q, main_d;
    ld_res_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept;

    load_extract #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_extract (
        .data_i   (in_data),
        .off_i    (in_off),
        .size_i   (in_size),
        .signed_i (in_signed),
        .tag_i    (in_tag),
        .res_o    (ext_res)
    );

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q;

    // A full skid implies a full main register, so draining it takes priority over input.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                main_d      = ext_res;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = ext_res;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q.data[DATA_W-1:0];
    assign out_tag   = main_q.tag[TAG_W-1:0];
    assign out_err   = main_q.err;

    // Padding bits of the record above DATA_W/TAG_W are always zero.
    logic unused_pad;
    assign unused_pad = ^{main_q.data, main_q.tag};

endmodule

// File: tb/tb_load_align_extend.sv
// Self-checking bench for load_align_extend: directed vector table on 32/64-bit
// instances, handshake corner sequences and a randomized run against a queue model.
module tb_load_align_extend;

    logic        clk = 1'b0;
    logic        reset, flush, out_ready, v32, v64, sel64;
    logic [63:0] in_data;
    logic [2:0]  in_off;
    logic [1:0]  in_size;
    logic        in_signed;
    logic [4:0]  in_tag;

    logic        rdy32, rdy64, ov32, ov64, err32, err64;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [4:0]  t32, t64;

    logic        o_valid, o_rdy, o_err;
    logic [63:0] o_data;
    logic [4:0]  o_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_align_extend #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (v32),
        .in_ready  (rdy32),
        .in_data   (in_data[31:0]),
        .in_off    (in_off[1:0]),
        .in_size   (in_size),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (ov32),
        .out_ready (out_ready),
        .out_data  (d32),
        .out_tag   (t32),
        .out_err   (err32)
    );

    load_align_extend #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (v64),
        .in_ready  (rdy64),
        .in_data   (in_data),
        .in_off    (in_off),
        .in_size   (in_size),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (ov64),
        .out_ready (out_ready),
        .out_data  (d64),
        .out_tag   (t64),
        .out_err   (err64)
    );

    always_comb begin
        if (sel64) begin
            o_valid = ov64; o_rdy = rdy64; o_err = err64; o_data = d64; o_tag = t64;
        end else begin
            o_valid = ov32; o_rdy = rdy32; o_err = err32; o_data = 64'(d32); o_tag = t32;
        end
    end

    typedef struct {
        logic [63:0] data;
        logic [2:0]  off;
        logic [1:0]  size;
        logic        sgn;
        logic [4:0]  tag;
        logic [63:0] exp;
        logic        err;
        logic        w64;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift the word down by whole bytes, keep 2^size bytes, extend if asked.
    function automatic void ref_ld(input bit w64, input logic [63:0] d, input int unsigned off,
                                   input logic [1:0] sz, input bit sg,
                                   output logic [63:0] r, output bit e);
        int unsigned nb;
        logic [63:0] f, m;
        nb = 32'd1 << sz;
        e  = ((off % nb) != 0) || (sz == 2'b11 && !w64);
        m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        f  = (d >> (8 * off)) & m;
        if (sg && f[8 * nb - 1]) f = f | ~m;
        if (!w64) f = f & 64'h0000_0000_FFFF_FFFF;
        r = e ? 64'd0 : f;
    endfunction

    task automatic run_random(input bit w64, input int n);
        logic [63:0] qd[$];
        logic [4:0]  qt[$];
        bit          qe[$];
        logic [63:0] rd;
        logic [4:0]  rt;
        bit          re;
        bit          vin, fl, tail;
        sel64 = w64; v32 = 1'b0; v64 = 1'b0; out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            tail      = (i >= n - 4);
            in_data   = {$urandom, $urandom};
            if (!w64) in_data[63:32] = '0;
            in_off    = w64 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            in_size   = 2'($urandom_range(0, 3));
            in_signed = 1'($urandom);
            in_tag    = 5'($urandom);
            vin       = !tail && ($urandom_range(0, 3) != 0);
            fl        = !tail && ($urandom_range(0, 31) == 0);
            out_ready = tail || (!fl && ($urandom_range(0, 2) != 0));
            flush     = fl;
            v32       = vin && !w64;
            v64       = vin && w64;
            chk("rand_in_ready", 64'(o_rdy), 64'(qd.size() < 2));
            chk("rand_out_valid", 64'(o_valid), 64'(qd.size() > 0));
            if (out_ready && qd.size() > 0) begin
                rd = qd.pop_front();
                rt = qt.pop_front();
                re = qe.pop_front();
                chk("rand_data", o_data, rd);
                chk("rand_tag", 64'(o_tag), 64'(rt));
                chk("rand_err", 64'(o_err), 64'(re));
            end
            if (fl) begin
                qd.delete(); qt.delete(); qe.delete();
            end else if (vin && o_rdy) begin
                ref_ld(w64, in_data, int'(in_off), in_size, in_signed, rd, re);
                qd.push_back(rd); qt.push_back(in_tag); qe.push_back(re);
            end
            step();
        end
        flush = 1'b0; v32 = 1'b0; v64 = 1'b0;
        chk("rand_drained", 64'(o_valid), 64'(qd.size() > 0));
    endtask

    initial begin
        vecs.push_back('{64'h1280_3456, 3'd2, 2'b00, 1'b1, 5'd1, 64'hFFFF_FF80, 1'b0, 1'b0});
        vecs.push_back('{64'h1280_3456, 3'd2, 2'b00, 1'b0, 5'd2, 64'h0000_0080, 1'b0, 1'b0});
        vecs.push_back('{64'h1280_3456, 3'd2, 2'b01, 1'b1, 5'd3, 64'h0000_1280, 1'b0, 1'b0});
        vecs.push_back('{64'h0000_8001, 3'd0, 2'b01, 1'b1, 5'd4, 64'hFFFF_8001, 1'b0, 1'b0});
        vecs.push_back('{64'h0000_8001, 3'd1, 2'b01, 1'b1, 5'd5, 64'h0, 1'b1, 1'b0});
        vecs.push_back('{64'h1280_3456, 3'd0, 2'b11, 1'b0, 5'd6, 64'h0, 1'b1, 1'b0});
        vecs.push_back('{64'h8000_0000, 3'd0, 2'b10, 1'b1, 5'd7, 64'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{64'h8000_0000, 3'd2, 2'b10, 1'b0, 5'd8, 64'h0, 1'b1, 1'b0});
        vecs.push_back('{64'hAB00_0000, 3'd3, 2'b00, 1'b0, 5'd9, 64'h0000_00AB, 1'b0, 1'b0});
        vecs.push_back('{64'hFFFE_0000, 3'd2, 2'b01, 1'b1, 5'd10, 64'hFFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{64'h8000_0000_0000_0000, 3'd0, 2'b11, 1'b0, 5'd11,
                         64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vecs.push_back('{64'hFFFF_FFFE_0000_0000, 3'd4, 2'b10, 1'b1, 5'd12,
                         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1});
        vecs.push_back('{64'hFFFF_FFFE_0000_0000, 3'd4, 2'b10, 1'b0, 5'd13,
                         64'h0000_0000_FFFF_FFFE, 1'b0, 1'b1});
        vecs.push_back('{64'hFFFF_FFFE_0000_0000, 3'd4, 2'b11, 1'b0, 5'd14, 64'h0, 1'b1, 1'b1});
        vecs.push_back('{64'h8000_0000_0000_0000, 3'd7, 2'b00, 1'b1, 5'd15,
                         64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1});
        vecs.push_back('{64'h0000_1234_0000_0000, 3'd4, 2'b01, 1'b0, 5'd16,
                         64'h0000_0000_0000_1234, 1'b0, 1'b1});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 3'd6, 2'b01, 1'b0, 5'd17,
                         64'h0000_0000_0000_1234, 1'b0, 1'b1});

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; v32 = 1'b0; v64 = 1'b0; sel64 = 1'b0;
        in_data = '0; in_off = '0; in_size = '0; in_signed = 1'b0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(o_valid), 64'd0);
        chk("rst_in_ready", 64'(o_rdy), 64'd1);
        chk("rst_out_data", o_data, 64'd0);
        chk("rst_out_tag", 64'(o_tag), 64'd0);
        chk("rst_out_err", 64'(o_err), 64'd0);
        chk("rst64_in_ready", 64'(rdy64), 64'd1);
        #4 reset = 1'b0;

        // Directed table
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            sel64 = vecs[i].w64;
            in_data = vecs[i].data; in_off = vecs[i].off; in_size = vecs[i].size;
            in_signed = vecs[i].sgn; in_tag = vecs[i].tag;
            v32 = !vecs[i].w64; v64 = vecs[i].w64;
            if (i == 0) chk("latency_not_same_cycle", 64'(o_valid), 64'd0);
            step();
            v32 = 1'b0; v64 = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(o_valid), 64'd1);
            chk($sformatf("vec%0d_data", i), o_data, vecs[i].exp);
            chk($sformatf("vec%0d_err", i), 64'(o_err), 64'(vecs[i].err));
            chk($sformatf("vec%0d_tag", i), 64'(o_tag), 64'(vecs[i].tag));
        end
        step();
        sel64 = 1'b0;

        // Back-pressure: three offers against a stalled consumer
        out_ready = 1'b0; in_size = 2'b00; in_signed = 1'b0; in_off = '0;
        in_tag = 5'd1; in_data = 64'h11; v32 = 1'b1;
        step();
        chk("bp_t1_valid", 64'(o_valid), 64'd1);
        chk("bp_t1_tag", 64'(o_tag), 64'd1);
        chk("bp_rdy_after1", 64'(o_rdy), 64'd1);
        in_tag = 5'd2; in_data = 64'h22;
        step();
        chk("bp_rdy_3rd_offer", 64'(o_rdy), 64'd0);
        chk("bp_hold_tag", 64'(o_tag), 64'd1);
        in_tag = 5'd3; in_data = 64'h33;
        step();
        chk("bp_hold_tag2", 64'(o_tag), 64'd1);
        chk("bp_hold_data", o_data, 64'h11);
        chk("bp_rdy_still0", 64'(o_rdy), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_seq2_valid", 64'(o_valid), 64'd1);
        chk("bp_seq2_tag", 64'(o_tag), 64'd2);
        chk("bp_seq2_data", o_data, 64'h22);
        chk("bp_rdy_drained", 64'(o_rdy), 64'd1);
        step();
        chk("bp_seq3_valid", 64'(o_valid), 64'd1);
        chk("bp_seq3_tag", 64'(o_tag), 64'd3);
        chk("bp_seq3_data", o_data, 64'h33);
        v32 = 1'b0;
        step();
        chk("bp_empty", 64'(o_valid), 64'd0);

        // Flush with main and skid full
        out_ready = 1'b0; v32 = 1'b1;
        in_tag = 5'd4; in_data = 64'h44; step();
        in_tag = 5'd5; in_data = 64'h55; step();
        chk("fl_full_rdy", 64'(o_rdy), 64'd0);
        flush = 1'b1; in_tag = 5'd6; in_data = 64'h66;
        step();
        flush = 1'b0; v32 = 1'b0;
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_rdy", 64'(o_rdy), 64'd1);
        flush = 1'b1; v32 = 1'b1; in_tag = 5'd7; in_data = 64'h77;
        step();
        flush = 1'b0; v32 = 1'b0;
        chk("fl_drop_input", 64'(o_valid), 64'd0);
        out_ready = 1'b1; v32 = 1'b1; in_tag = 5'd8; in_data = 64'h88;
        step();
        v32 = 1'b0;
        chk("fl_new_valid", 64'(o_valid), 64'd1);
        chk("fl_new_tag", 64'(o_tag), 64'd8);
        chk("fl_new_data", o_data, 64'h88);
        step();
        chk("fl_no_stale", 64'(o_valid), 64'd0);

        // Asynchronous reset with the skid full
        out_ready = 1'b0; v32 = 1'b1;
        in_tag = 5'd9; in_data = 64'h99; step();
        in_tag = 5'd10; in_data = 64'hAA; step();
        v32 = 1'b0;
        chk("ar_full_rdy", 64'(o_rdy), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 64'(o_valid), 64'd0);
        chk("ar_rdy", 64'(o_rdy), 64'd1);
        chk("ar_data", o_data, 64'd0);
        chk("ar_tag", 64'(o_tag), 64'd0);
        #1 reset = 1'b0;
        out_ready = 1'b1; v32 = 1'b1; in_tag = 5'd12; in_data = 64'h0C;
        step();
        v32 = 1'b0;
        chk("ar_new_valid", 64'(o_valid), 64'd1);
        chk("ar_new_tag", 64'(o_tag), 64'd12);
        step();
        chk("ar_no_stale", 64'(o_valid), 64'd0);

        run_random(1'b0, 400);
        run_random(1'b1, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
